sa_job_sequencer: RTL
=====================

Name: sa_job_sequencer

Overview:
- Sequences one matrix job on the FP32×int8 pipelined systolic array of SA_SIZE×SA_SIZE PEs.
- Optionally loads SA_SIZE²/4 packed weight words.
- Streams num_rows activation rows with per-row diagonal skew.
- Drains the array with zero rows until every issued token has produced an output beat, then pulses done.
- Sits between the accelerator's weight/activation stream sources and the array's cmd/weight_input/inputs ports.

Parameters:
- SA_SIZE, 8, array dimension; multiple of 4 and at least 4.
- ACT_W, 32, activation width (FP32); fixed.
- ROWS_W, 16, width of the num_rows job field.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  job start pulse; sampled only in IDLE
- reload_weights  in  1  sampled with start; 1 = run LOAD_W before streaming
- num_rows  in  ROWS_W  activation rows in the job; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- w_valid  in  1  weight word valid
- w_ready  out  1  weight word accepted
- w_data  in  32  four int8 weights; [31:24] to column 0 … [7:0] to column 3
- a_valid  in  1  activation row valid
- a_ready  out  1  activation row accepted
- a_data  in  SA_SIZE*ACT_W  row; element r at [r*ACT_W +: ACT_W]
- sa_cmd  out  command_t  CMD_IDLE / CMD_WRITE_WEIGHTS / CMD_STREAM
- sa_weight_input  out  32  weight word to the array
- sa_inputs  out  SA_SIZE*ACT_W  skewed activations, element r feeds array row r
- sa_outputs_valid  in  1  array output beat strobe

Behaviour:
- Reset: FSM to IDLE; busy=0, done=0, w_ready=0, a_ready=0, sa_cmd=CMD_IDLE; skew registers, counters and sa_weight_input all 0. Reset mid-job aborts with no done.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE, start=1, registering num_rows and reload_weights:
  - reload=1 → LOAD_W.
  - reload=0 and num_rows>0 → STREAM.
  - reload=0 and num_rows=0 → DONE.
- start outside IDLE is ignored.
- LOAD_W:
  - w_ready=1.
  - Each cycle with w_valid&&w_ready, sa_cmd=CMD_WRITE_WEIGHTS and sa_weight_input=w_data, combinationally in the same cycle. All other cycles: CMD_IDLE.
  - After the N_WWORDS=SA_SIZE²/4-th accepted word: go to STREAM if num_rows>0, else DONE.
  - Word order is the producer's responsibility: last array words first.
- STREAM:
  - a_ready=1.
  - On each a_valid&&a_ready cycle (a "beat"): sa_cmd=CMD_STREAM and the skew buffer advances with a_data. No beat: CMD_IDLE, buffer holds.
  - After num_rows beats → DRAIN.
- DRAIN:
  - a_ready=0.
  - Every cycle is a beat: sa_cmd=CMD_STREAM with zero row input.
  - Leave when out_cnt == num_rows + 2*SA_SIZE − 2 → DONE.
- out_cnt:
  - Counts sa_outputs_valid pulses from job start.
  - Pulses in IDLE/LOAD_W/DONE are ignored.
  - Width ROWS_W+1, saturating.
- DONE: done=1 for one cycle, sa_cmd=CMD_IDLE → IDLE.
- Skew buffer:
  - Row r output = row-r input delayed by r beats; row 0 is combinational passthrough of the beat input.
  - Shift registers advance only on beats.
  - sa_inputs is valid whenever sa_cmd=CMD_STREAM.
- Exactly one of the WRITE_WEIGHTS or STREAM commands per cycle; never both.
- w_ready and a_ready are never both high.

Decomposition:
- TicSAT_pkg holds:
  - command_t including CMD_IDLE.
  - New seq_state_t enum.
  - Helper function n_weight_words(SA_SIZE).
- Sub-module sa_input_skew (params SA_SIZE, ACT_W; ports clk, resetn, advance, in_row, out_row) implements the per-row delay lines.

Test Plan:
(SA_SIZE=4 for all scenarios.)
- Weight load with gaps: start, reload=1, num_rows=0; w_valid high on 4 of 7 cycles with words 0x01020304…0x0D0E0F10 → exactly 4 CMD_WRITE_WEIGHTS cycles carrying those words in order, then a done pulse; busy low the next cycle.
- Skew: num_rows=1, row = {1.0, 2.0, 3.0, 4.0}, with a 1:1 model array → sa_inputs[0]=0x3F800000 on beat 1, sa_inputs[3]=0x40800000 on beat 4, zeros elsewhere; 7 total CMD_STREAM beats once the model returns 7 output strobes.
- Backpressure: num_rows=3 with a_valid toggling 1,0,1,0,1 → CMD_IDLE on the gap cycles, skew contents held, 3 STREAM-state beats, and done only after out_cnt=9.
- Ignored start and reuse: start pulsed during DRAIN has no effect; a second job with reload=0 skips LOAD_W (w_ready stays 0).
- Reset mid-STREAM → next cycle sa_cmd=CMD_IDLE, busy=0, sa_inputs all zero, no done pulse.
- Spurious strobe: sa_outputs_valid pulse in IDLE, then a job with num_rows=2 → done only after 8 in-job strobes.

Source files
------------

// File: rtl/TicSAT_pkg.sv
// Shared types and helpers for the systolic-array command interface and
// the job sequencer that drives it.
package TicSAT_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE          = 2'd0,
        CMD_WRITE_WEIGHTS = 2'd1,
        CMD_STREAM        = 2'd2
    } command_t;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_LOAD_W = 3'd1,
        SEQ_STREAM = 3'd2,
        SEQ_DRAIN  = 3'd3,
        SEQ_DONE   = 3'd4
    } seq_state_t;

    // Each 32-bit weight word carries four int8 weights.
    function automatic int unsigned n_weight_words(input int unsigned sa_size);
        return (sa_size * sa_size) / 32'd4;
    endfunction

endpackage

// File: rtl/sa_input_skew.sv
// Per-row diagonal skew: row r of the output is row r of the input delayed by
// r beats; row 0 passes straight through.
module sa_input_skew #(
    parameter int SA_SIZE = 8,
    parameter int ACT_W   = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     advance,
    input  logic [SA_SIZE*ACT_W-1:0] in_row,
    output logic [SA_SIZE*ACT_W-1:0] out_row
);

    assign out_row[0 +: ACT_W] = in_row[0 +: ACT_W];

    for (genvar r = 1; r < SA_SIZE; r++) begin : g_row
        logic [ACT_W-1:0] dl [r];

        // Delay line for row r; shifts only when the array consumes a beat.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                for (int k = 0; k < r; k++) dl[k] <= '0;
            end else if (advance) begin
                dl[0] <= in_row[r*ACT_W +: ACT_W];
                for (int k = 1; k < r; k++) dl[k] <= dl[k-1];
            end
        end

        assign out_row[r*ACT_W +: ACT_W] = dl[r-1];
    end

endmodule

// File: rtl/sa_job_sequencer.sv
// Sequences one matrix job on the systolic array: optional weight load,
// skewed activation streaming, then zero-row drain until all outputs return.
module sa_job_sequencer
    import TicSAT_pkg::*;
#(
    parameter int SA_SIZE = 8,
    parameter int ACT_W   = 32,
    parameter int ROWS_W  = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     reload_weights,
    input  logic [ROWS_W-1:0]        num_rows,
    output logic                     busy,
    output logic                     done,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [31:0]              w_data,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [SA_SIZE*ACT_W-1:0] a_data,
    output command_t                 sa_cmd,
    output logic [31:0]              sa_weight_input,
    output logic [SA_SIZE*ACT_W-1:0] sa_inputs,
    input  logic                     sa_outputs_valid
);

    localparam int N_WWORDS = int'(n_weight_words(SA_SIZE));
    localparam int WCNT_W   = $clog2(N_WWORDS);
    // A token entering row 0 needs 2*SA_SIZE-2 extra beats to reach the far corner.
    localparam logic [ROWS_W:0] DRAIN_EXTRA = (ROWS_W+1)'(2*SA_SIZE-2);
    localparam logic [ROWS_W:0] OUT_CNT_MAX = '1;

    seq_state_t                 state_r, state_s;
    logic [ROWS_W-1:0]          num_rows_r;
    logic [WCNT_W-1:0]          wcnt_r;
    logic [ROWS_W-1:0]          beat_cnt_r;
    logic [ROWS_W:0]            out_cnt_r, out_cnt_s;
    logic [ROWS_W:0]            drain_target_s;
    logic                       beat_s;
    logic [SA_SIZE*ACT_W-1:0]   skew_in_s;

    assign drain_target_s = {1'b0, num_rows_r} + DRAIN_EXTRA;

    // Saturating count of in-job output strobes; strobes outside STREAM/DRAIN are ignored.
    always_comb begin
        out_cnt_s = out_cnt_r;
        if ((state_r == SEQ_STREAM || state_r == SEQ_DRAIN) && sa_outputs_valid
            && (out_cnt_r != OUT_CNT_MAX)) begin
            out_cnt_s = out_cnt_r + (ROWS_W+1)'(1);
        end else begin
            out_cnt_s = out_cnt_r;
        end
    end

    // State register and job counters; all counters restart when a job is accepted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= SEQ_IDLE;
            num_rows_r <= '0;
            wcnt_r     <= '0;
            beat_cnt_r <= '0;
            out_cnt_r  <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == SEQ_IDLE && start) begin
                num_rows_r <= num_rows;
                wcnt_r     <= '0;
                beat_cnt_r <= '0;
                out_cnt_r  <= '0;
            end else begin
                out_cnt_r <= out_cnt_s;
                if (state_r == SEQ_LOAD_W && w_valid) wcnt_r <= wcnt_r + WCNT_W'(1);
                if (state_r == SEQ_STREAM && a_valid) beat_cnt_r <= beat_cnt_r + ROWS_W'(1);
            end
        end
    end

    // Next-state and array command decode.
    always_comb begin
        state_s         = state_r;
        sa_cmd          = CMD_IDLE;
        sa_weight_input = 32'd0;
        w_ready         = 1'b0;
        a_ready         = 1'b0;
        beat_s          = 1'b0;
        skew_in_s       = '0;
        busy            = (state_r != SEQ_IDLE);
        done            = (state_r == SEQ_DONE);
        case (state_r)
            SEQ_IDLE: begin
                if (start) begin
                    if (reload_weights)            state_s = SEQ_LOAD_W;
                    else if (num_rows != '0)       state_s = SEQ_STREAM;
                    else                           state_s = SEQ_DONE;
                end else begin
                    state_s = SEQ_IDLE;
                end
            end
            SEQ_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    sa_cmd          = CMD_WRITE_WEIGHTS;
                    sa_weight_input = w_data;
                    if (wcnt_r == WCNT_W'(N_WWORDS-1)) begin
                        state_s = (num_rows_r != '0) ? SEQ_STREAM : SEQ_DONE;
                    end else begin
                        state_s = SEQ_LOAD_W;
                    end
                end else begin
                    state_s = SEQ_LOAD_W;
                end
            end
            SEQ_STREAM: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    sa_cmd    = CMD_STREAM;
                    beat_s    = 1'b1;
                    skew_in_s = a_data;
                    if (beat_cnt_r == num_rows_r - ROWS_W'(1)) state_s = SEQ_DRAIN;
                    else                                       state_s = SEQ_STREAM;
                end else begin
                    state_s = SEQ_STREAM;
                end
            end
            SEQ_DRAIN: begin
                sa_cmd = CMD_STREAM;
                beat_s = 1'b1;
                // The strobe arriving this cycle counts toward the exit condition.
                if (out_cnt_s >= drain_target_s) state_s = SEQ_DONE;
                else                             state_s = SEQ_DRAIN;
            end
            SEQ_DONE: begin
                state_s = SEQ_IDLE;
            end
            default: begin
                state_s = SEQ_IDLE;
            end
        endcase
    end

    sa_input_skew #(
        .SA_SIZE (SA_SIZE),
        .ACT_W   (ACT_W)
    ) u_skew (
        .clk     (clk),
        .resetn  (resetn),
        .advance (beat_s),
        .in_row  (skew_in_s),
        .out_row (sa_inputs)
    );

endmodule
